// File: rtl/insn_fetch_queue_pkg.sv
// Shared widths and types for the instruction fetch front end.
// An entry pairs a returned instruction word with the PC it was fetched from.
package insn_fetch_queue_pkg;

    localparam int INSN_ADDR_WIDTH = 32;
    localparam int INSN_WIDTH      = 32;
    localparam int FETCH_DEPTH     = 4;

    typedef logic [INSN_ADDR_WIDTH-1:0] insn_addr_t;
    typedef logic [INSN_WIDTH-1:0]      insn_t;

    typedef struct packed {
        insn_t      insn;
        insn_addr_t pc;
    } fetch_entry_t;

    function automatic int fetch_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/insn_fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with synchronous clear and async reset.
// Clear wins over push/pop; pop on empty and push on full are ignored.
module insn_fetch_queue_fifo
    import insn_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  fetch_entry_t         push_data,
    input  logic                 pop,
    output fetch_entry_t         head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0) && !clear;
        do_push = push && (count_q != CNT_W'(DEPTH)) && !clear;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (do_pop)  head_d = head_q + PTR_W'(1);
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_data;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/insn_fetch_queue.sv
// Prefetching fetch front end: owns the fetch PC, issues reads while queue credit
// remains, buffers responses in a FIFO and flushes everything on redirect.
module insn_fetch_queue
    import insn_fetch_queue_pkg::*;
#(
    parameter int         DEPTH    = FETCH_DEPTH,
    parameter insn_addr_t RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output insn_addr_t             insnAddr,
    output logic                   fetchEnable,
    input  insn_t                  insn,
    input  logic                   redirect,
    input  insn_addr_t             redirectAddr,
    output logic                   deqValid,
    output insn_t                  deqInsn,
    output insn_addr_t             deqPC,
    input  logic                   deqReady,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    insn_addr_t   fetch_pc_q, fetch_pc_d;
    insn_addr_t   inflight_pc_q, inflight_pc_d;
    logic         inflight_valid_q, inflight_valid_d;
    logic [CNT_W:0] demand;
    logic         push, pop;
    fetch_entry_t push_data, head;

    always_comb begin
        // Credit counts the outstanding read but never a same-cycle pop.
        demand        = {1'b0, count} + {{CNT_W{1'b0}}, inflight_valid_q};
        fetchEnable   = !redirect && (demand < (CNT_W+1)'(DEPTH));
        push          = inflight_valid_q && !redirect;
        pop           = deqValid && deqReady && !redirect;
        push_data     = '{insn: insn, pc: inflight_pc_q};

        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = fetchEnable;
        if (redirect) begin
            fetch_pc_d = redirectAddr;
        end else if (fetchEnable) begin
            fetch_pc_d    = fetch_pc_q + 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q       <= RESET_PC;
            inflight_pc_q    <= '0;
            inflight_valid_q <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
        end
    end

    insn_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign insnAddr = fetch_pc_q;
    assign deqValid = (count != '0);
    assign deqInsn  = head.insn;
    assign deqPC    = head.pc;

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Bench for insn_fetch_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the fetch front end.
`timescale 1ns/1ps
module tb_insn_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] insnAddr, insn, redirectAddr, deqInsn, deqPC;
    logic        fetchEnable, redirect, deqValid, deqReady;
    logic [2:0]  count;

    logic [31:0] insnAddr1, insn1, deqInsn1, deqPC1;
    logic        fetchEnable1, deqValid1;
    logic [2:0]  count1;

    int n_checks = 0;
    int n_err    = 0;
    bit done1    = 0;

    insn_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .insnAddr(insnAddr), .fetchEnable(fetchEnable),
        .insn(insn), .redirect(redirect), .redirectAddr(redirectAddr),
        .deqValid(deqValid), .deqInsn(deqInsn), .deqPC(deqPC),
        .deqReady(deqReady), .count(count)
    );

    insn_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFF)) dut1 (
        .clk(clk), .rst(rst), .insnAddr(insnAddr1), .fetchEnable(fetchEnable1),
        .insn(insn1), .redirect(1'b0), .redirectAddr(32'h0),
        .deqValid(deqValid1), .deqInsn(deqInsn1), .deqPC(deqPC1),
        .deqReady(1'b1), .count(count1)
    );

    // clock / memory responders: data for last cycle's address is addr + 0x100
    always #10 clk = ~clk;
    always @(posedge clk) insn  <= insnAddr  + 32'h100;
    always @(posedge clk) insn1 <= insnAddr1 + 32'h100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: queue of {insn, pc}, one outstanding read, fetch PC
    logic [63:0] m_q[$];
    logic [31:0] m_pc, m_infl_pc;
    bit          m_infl;

    function automatic void model_reset();
        m_q.delete();
        m_pc      = 32'h0;
        m_infl    = 0;
        m_infl_pc = 32'h0;
    endfunction

    function automatic bit model_fe(input logic r);
        return !r && (m_q.size() + int'(m_infl) < DEPTH);
    endfunction

    function automatic void model_step(input logic r, input logic [31:0] ra, input logic rdy);
        bit fe;
        fe = model_fe(r);
        if (r) begin
            m_q.delete();
            m_infl = 0;
            m_pc   = ra;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (m_infl) m_q.push_back({m_infl_pc + 32'h100, m_infl_pc});
            if (fe) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'h1;
            end
            m_infl = fe;
        end
    endfunction

    always @(posedge rst) model_reset();

    // compare process: inputs change at negedge, outputs settle by +2
    always @(negedge clk) begin
        #2;
        if (rst) begin
            model_reset();
        end else begin
            check("count", 64'(count), 64'(m_q.size()));
            check("deq_valid", 64'(deqValid), 64'(m_q.size() != 0));
            check("insn_addr", 64'(insnAddr), 64'(m_pc));
            check("fetch_enable", 64'(fetchEnable), 64'(model_fe(redirect)));
            if (m_q.size() != 0) begin
                check("deq_pc", 64'(deqPC), 64'(m_q[0][31:0]));
                check("deq_insn", 64'(deqInsn), 64'(m_q[0][63:32]));
            end
            if (dut.inflight_valid_q && !redirect && count == 3'(DEPTH)) begin
                n_err++;
                $display("FAIL push_while_full: count %0d with a pending push", count);
            end
            model_step(redirect, redirectAddr, deqReady);
        end
    end

    task automatic tick(input logic r, input logic [31:0] ra, input logic rdy);
        @(negedge clk);
        redirect     = r;
        redirectAddr = ra;
        deqReady     = rdy;
        #3;
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst      = 1'b1;
        redirect = 1'b0;
        deqReady = rdy;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #3;
    endtask

    // RESET_PC all-ones instance: PC sequence wraps through zero
    initial begin
        bit seen;
        @(negedge rst);
        #3;
        check("wrap_first_addr", 64'(insnAddr1), 64'h0000_0000_FFFF_FFFF);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #3;
            if (deqValid1) seen = 1;
        end
        check("wrap_deq_seen", 64'(seen), 64'h1);
        check("wrap_pc0", 64'(deqPC1), 64'h0000_0000_FFFF_FFFF);
        check("wrap_insn0", 64'(deqInsn1), 64'h0000_0000_0000_00FF);
        @(negedge clk);
        #3;
        check("wrap_pc1", 64'(deqPC1), 64'h0);
        check("wrap_insn1", 64'(deqInsn1), 64'h100);
        done1 = 1;
    end

    initial begin
        redirect     = 1'b0;
        redirectAddr = 32'h0;
        deqReady     = 1'b1;
        #3;
        check("reset_count", 64'(count), 64'h0);
        check("reset_deq_valid", 64'(deqValid), 64'h0);
        check("reset_addr", 64'(insnAddr), 64'h0);

        // streaming with deqReady high
        do_reset(1'b1);
        check("release_fetch_enable", 64'(fetchEnable), 64'h1);
        tick(0, 0, 1);
        check("stream_addr1", 64'(insnAddr), 64'h1);
        check("stream_not_valid_t1", 64'(deqValid), 64'h0);
        tick(0, 0, 1);
        check("stream_valid_t2", 64'(deqValid), 64'h1);
        check("stream_pc0", 64'(deqPC), 64'h0);
        check("stream_insn0", 64'(deqInsn), 64'h100);
        tick(0, 0, 1);
        check("stream_pc1", 64'(deqPC), 64'h1);
        check("stream_insn1", 64'(deqInsn), 64'h101);
        repeat (6) begin
            tick(0, 0, 1);
            check("stream_count_le2", 64'(count <= 3'd2), 64'h1);
        end

        // fill with deqReady low, then drain
        do_reset(1'b0);
        repeat (6) tick(0, 0, 0);
        check("full_count", 64'(count), 64'd4);
        check("full_fetch_off", 64'(fetchEnable), 64'h0);
        check("full_addr", 64'(insnAddr), 64'h4);
        tick(0, 0, 1);
        check("drain_pc0", 64'(deqPC), 64'h0);
        check("drain_no_credit", 64'(fetchEnable), 64'h0);
        tick(0, 0, 1);
        check("drain_pc1", 64'(deqPC), 64'h1);
        check("resume_enable", 64'(fetchEnable), 64'h1);
        check("resume_addr", 64'(insnAddr), 64'h4);
        tick(0, 0, 1);
        check("drain_pc2", 64'(deqPC), 64'h2);
        tick(0, 0, 1);
        check("drain_pc3", 64'(deqPC), 64'h3);

        // redirect with count 3, read in flight, deqReady high and a pending push
        do_reset(1'b0);
        repeat (4) tick(0, 0, 0);
        check("pre_redirect_count", 64'(count), 64'd3);
        tick(1, 32'h40, 1);
        check("redirect_fe_low", 64'(fetchEnable), 64'h0);
        tick(0, 0, 1);
        check("redirect_count0", 64'(count), 64'h0);
        check("redirect_addr", 64'(insnAddr), 64'h40);
        tick(0, 0, 1);
        check("redirect_r2_empty", 64'(deqValid), 64'h0);
        tick(0, 0, 1);
        check("redirect_r3_valid", 64'(deqValid), 64'h1);
        check("redirect_r3_pc", 64'(deqPC), 64'h40);
        check("redirect_r3_insn", 64'(deqInsn), 64'h140);

        // async reset mid-cycle with two entries queued
        do_reset(1'b0);
        repeat (3) tick(0, 0, 0);
        check("pre_async_count", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #2;
        check("async_count", 64'(count), 64'h0);
        check("async_deq_valid", 64'(deqValid), 64'h0);
        do_reset(1'b1);
        check("async_restart_addr", 64'(insnAddr), 64'h0);
        tick(0, 0, 1);
        check("async_restart_addr1", 64'(insnAddr), 64'h1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [31:0] ra;
            r  = ($urandom_range(0, 15) == 0);
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            tick(r, ra, ($urandom_range(0, 9) < 6));
        end
        tick(0, 0, 1);

        wait (done1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/insn_fetch_queue.md
# insn_fetch_queue

Prefetching instruction-fetch front end between the synchronous instruction memory and the IF/ID pipeline register. It owns the fetch PC, issues one read address per cycle while queue credit remains, and buffers returned instruction words with their PCs in a small FIFO. The decode side pops entries with a valid/ready handshake. A redirect from the branch unit flushes the FIFO, discards any in-flight read and restarts fetch at the target.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- insnAddr  out  `INSN_ADDR_WIDTH  instruction-memory read address; word-addressed.
- fetchEnable  out  1  read request; memory returns `insn` in the following cycle.
- insn  in  `INSN_WIDTH  read data for the address issued in the previous cycle.
- redirect  in  1  branch taken or flush request.
- redirectAddr  in  `INSN_ADDR_WIDTH  restart PC.
- deqValid  out  1  head entry is valid.
- deqInsn  out  `INSN_WIDTH  head instruction.
- deqPC  out  `INSN_ADDR_WIDTH  PC of the head instruction.
- deqReady  in  1  consumer accepts the head this cycle; low while IF/ID stalls.
- count  out  `FetchCountPath  current occupancy, 0 to DEPTH.

## Operation
- State registers: fetchPC; inflightValid and inflightPC (at most 1 outstanding read); FIFO storage plus head/tail pointers and count.
- Combinational outputs:
  - insnAddr = fetchPC.
  - fetchEnable = !redirect && (count + inflightValid < DEPTH).
  - Issue credit never counts a same-cycle pop.
- Issue: on a cycle with fetchEnable high,
  - fetchPC <= fetchPC + 1, wrapping from all-ones to 0;
  - inflightValid <= 1 and inflightPC <= fetchPC.
  - Otherwise inflightValid <= 0.
- Push: when inflightValid is high and redirect is low, write {insn, inflightPC} at tail and advance tail modulo DEPTH.
- Pop: when deqValid && deqReady && !redirect, advance head modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- deqValid = (count != 0). deqInsn and deqPC are taken from the head entry and are don't-care while deqValid is low.
- Redirect has priority over everything in the same cycle:
  - head, tail and count are cleared to 0;
  - the in-flight response is discarded (inflightValid <= 0);
  - fetchPC <= redirectAddr;
  - pop and push are suppressed and fetchEnable is 0.
- Pop with count 0 is ignored. Push while full cannot occur because of the credit rule; the bench asserts this.
- Reset mid-operation immediately clears all state regardless of any outstanding request.

## Timing
- Reset values: fetchPC = RESET_PC, inflightValid = 0, count = 0, deqValid = 0, head = tail = 0. fetchEnable = 1 as soon as rst deasserts.
- Fetch latency: address issued in cycle t; data is pushed at the edge ending t+1; deqValid is high in t+2. There is no bypass.
- Redirect latency: redirect in cycle r; first new address issued in r+1; deqValid with deqPC = redirectAddr in r+3.
- Throughput: with deqReady held high, one instruction per cycle after the first fill. Steady-state count stays at or below 2.
- With deqReady low, issue stops once count + inflightValid = DEPTH. Exactly DEPTH entries are held and none are lost.

## Structure
- Types.v gains:
  - `FETCH_DEPTH default;
  - `FetchCountPath, width $clog2(DEPTH)+1;
  - `FetchPtrPath;
  - a FetchEntry struct {insn, pc}.
- A single sub-module, fetch_fifo, is natural: a parameterised synchronous FIFO with push, pop, clear, count, head data and async reset. insn_fetch_queue adds the PC, credit logic, in-flight tracking and redirect handling around it.

## Test plan
- Reset release, RESET_PC=0, deqReady=1, memory returns addr+0x100: insnAddr 0,1,2… on consecutive cycles; deqValid first high 2 cycles after release with deqPC=0, deqInsn=0x100; then one entry per cycle in order.
- deqReady=0 from reset: exactly 4 issues (PCs 0–3), fetchEnable low thereafter, count=4. Raise deqReady: pops 0,1,2,3 in order, and fetch resumes at PC 4.
- Redirect to 0x40 while count=3 and a read is in flight: count=0 next cycle; stale data never appears on deq; first deqPC=0x40 three cycles after redirect.
- Redirect asserted together with deqReady and a pending push: no pop or push is taken and count goes to 0.
- RESET_PC = all-ones: sequence wraps to 0 and deqPC shows all-ones then 0.
- Async rst pulsed mid-cycle with count=2: deqValid and count drop to 0 without waiting for a clock edge; fetch restarts at RESET_PC after release.
